// File: rtl/fa4bit_pkg.sv
// ---------------------------------------------------------------------------
// fa4bit_pkg
// Shared definitions for the bit-serial adder:
//   FA_WIDTH : default operand/result width
//   state_t  : controller states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package fa4bit_pkg;

    localparam int FA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Combinational one-bit full adder.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : a ^ b ^ cin
//   o_co     : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_co
);

    assign o_sum = i_a ^ i_b ^ i_cin;
    assign o_co  = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/fa4bit_serial_adder.sv
// ---------------------------------------------------------------------------
// fa4bit_serial_adder
// Bit-serial WIDTH-bit adder that reuses one full_adder cell for every bit,
// LSB first, one bit per clock.
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous reset, active high
//   i_start     : request an addition (sampled only in IDLE)
//   i_a, i_b    : operands, captured on the accepting edge
//   i_cin       : carry in, captured on the accepting edge
//   o_busy      : high while bits are processed (RUN)
//   o_done      : one-cycle pulse when o_sum/o_cout hold a fresh result
//   o_sum       : result of last completed addition (held)
//   o_cout      : carry out of last completed addition (held)
//   o_dbg_state : current controller state
//
// Handshake: a request is accepted on a rising edge where the block is in
// IDLE and i_start is high. o_busy then stays high for exactly WIDTH cycles,
// followed by a single o_done cycle. i_start is ignored outside IDLE and is
// never queued.
// ---------------------------------------------------------------------------
module fa4bit_serial_adder
    import fa4bit_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_co;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_full_adder (
        .i_a   (r_a_sh[0]),
        .i_b   (r_b_sh[0]),
        .i_cin (r_carry),
        .o_sum (w_fa_sum),
        .o_co  (w_fa_co)
    );

    assign w_last = (r_cnt == LAST_CNT);

    // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached
    // bit 0. Written with shifts so it also holds for WIDTH == 1.
    assign w_s_next = (r_s_sh >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    // ---------------- FSM state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_s_sh  <= w_s_next;
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Result registers move only on the edge finishing the MSB,
                    // so the previous result stays visible throughout RUN.
                    if (w_last) begin
                        r_sum  <= w_s_next;
                        r_cout <= w_fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = (r_state == RUN);
    assign o_done      = (r_state == DONE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fa4bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_fa4bit_serial_adder
// Directed and randomized checks of the bit-serial adder at WIDTH=4 plus a
// WIDTH=1 instance. Expected results come from plain a+b+cin arithmetic and
// the documented cycle timing.
// ---------------------------------------------------------------------------
module tb_fa4bit_serial_adder;
    import fa4bit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- WIDTH=4 instance ----------------
    logic       start, cin, busy, done, cout;
    logic [3:0] a, b, sum;
    logic [1:0] dbg;

    fa4bit_serial_adder #(.WIDTH(4)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_sum       (sum),
        .o_cout      (cout),
        .o_dbg_state (dbg)
    );

    // ---------------- WIDTH=1 instance ----------------
    logic       w1_start, w1_a, w1_b, w1_cin, w1_busy, w1_done, w1_sum, w1_cout;
    logic [1:0] w1_dbg;

    fa4bit_serial_adder #(.WIDTH(1)) u_dut_w1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (w1_start),
        .i_a         (w1_a),
        .i_b         (w1_b),
        .i_cin       (w1_cin),
        .o_busy      (w1_busy),
        .o_done      (w1_done),
        .o_sum       (w1_sum),
        .o_cout      (w1_cout),
        .o_dbg_state (w1_dbg)
    );

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad   = 0;
    logic [4:0] prev_res;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition with start pulsed for a single cycle; checks busy window,
    // held result during RUN, the done pulse and the new result.
    task automatic run_add(input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic tc, input bit scramble);
        logic [4:0] exp_res;
        exp_res = 5'(ta) + 5'(tb_v) + 5'(tc);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scramble) begin
                a   = 4'($urandom);
                b   = 4'($urandom);
                cin = 1'($urandom);
            end
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("hold_res", 32'({cout, sum}), 32'(prev_res));
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("result", 32'({cout, sum}), 32'(exp_res));
        prev_res = exp_res;
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         pulses;
        int         pulse_at;
        int         cyc;
        int         last_cyc;
        int         pops;
        int         idx;
        bit         first;
        logic [8:0] combo;
        logic [1:0] w1_exp;

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        w1_start = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
        prev_res = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_sum",   32'(sum),  32'd0);
        check("rst_cout",  32'(cout), 32'd0);
        check("rst_state", 32'(dbg),  32'(IDLE));
        check("rst_w1",    32'({w1_busy, w1_done, w1_sum, w1_cout}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed additions
        run_add(4'd5,  4'd3,  1'b0, 1'b0);
        run_add(4'd15, 4'd1,  1'b0, 1'b0);
        run_add(4'd15, 4'd15, 1'b1, 1'b0);

        // start pulsed during RUN is ignored
        a = 4'd5; b = 4'd3; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                pulses++;
                pulse_at = i;
                check("ign_result", 32'({cout, sum}), 32'd8);
            end
            @(negedge clk);
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_pulse_at", 32'(pulse_at), 32'd2);
        prev_res = 5'd8;

        // Reset in the middle of RUN
        a = 4'd7; b = 4'd6; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_sum",   32'(sum),  32'd0);
        check("mid_rst_cout",  32'(cout), 32'd0);
        check("mid_rst_state", 32'(dbg),  32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        run_add(4'd9, 4'd4, 1'b1, 1'b0);

        // Random additions, random idle gaps, operands scrambled in flight
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_add(4'($urandom), 4'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        // Exhaustive sweep with start held high
        idx = 0;
        combo = 9'd0;
        a = combo[8:5]; b = combo[4:1]; cin = combo[0];
        exp_q.push_back(5'(a) + 5'(b) + 5'(cin));
        start = 1'b1;
        cyc = 0;
        last_cyc = 0;
        pops = 0;
        first = 1'b1;
        while (pops < 512 && cyc < 512 * 6 + 50) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("sweep_busy", 32'(busy), 32'd0);
                if (first) check("sweep_first_lat", 32'(cyc), 32'd5);
                else       check("sweep_spacing", 32'(cyc - last_cyc), 32'd6);
                first = 1'b0;
                last_cyc = cyc;
                if (exp_q.size() > 0) check("sweep_res", 32'({cout, sum}), 32'(exp_q.pop_front()));
                pops++;
                idx++;
                if (idx < 512) begin
                    combo = 9'(idx);
                    a = combo[8:5]; b = combo[4:1]; cin = combo[0];
                    exp_q.push_back(5'(a) + 5'(b) + 5'(cin));
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("sweep_count", 32'(pops), 32'd512);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // WIDTH=1 instance
        w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_start = 1'b1;
        @(negedge clk);
        w1_start = 1'b0;
        check("w1_busy", 32'(w1_busy), 32'd1);
        check("w1_done_early", 32'(w1_done), 32'd0);
        @(negedge clk);
        check("w1_done", 32'(w1_done), 32'd1);
        check("w1_busy_done", 32'(w1_busy), 32'd0);
        check("w1_res", 32'({w1_cout, w1_sum}), 32'd3);
        @(negedge clk);
        repeat (8) begin
            w1_a = 1'($urandom); w1_b = 1'($urandom); w1_cin = 1'($urandom);
            w1_exp = 2'(w1_a) + 2'(w1_b) + 2'(w1_cin);
            w1_start = 1'b1;
            @(negedge clk);
            w1_start = 1'b0;
            check("w1_rand_busy", 32'(w1_busy), 32'd1);
            @(negedge clk);
            check("w1_rand_done", 32'(w1_done), 32'd1);
            check("w1_rand_res", 32'({w1_cout, w1_sum}), 32'(w1_exp));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fa4bit_serial_adder.md
# fa4bit_serial_adder

Bit-serial WIDTH-bit adder that time-multiplexes a single one-bit full adder across all operand bits. It is the sequential stage wrapped around the one-bit full adder: it drives the adder's a/b/carry-in each cycle and consumes its sum/carry-out. It trades WIDTH cycles of latency for one adder cell. The start/busy/done handshake lets a controller or bench issue one addition at a time.

## Interface
- WIDTH, 4, operand and result width in bits; legal range is ≥ 1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when a result is valid.
- sum  output  WIDTH  result of the last completed addition; held between completions.
- cout  output  1  carry-out of the last completed addition; held between completions.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - load a_sh←a, b_sh←b, carry←cin, cnt←0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - full adder inputs are a_sh[0], b_sh[0] and carry;
  - a_sh and b_sh shift right by one;
  - s_sh shifts right with the adder sum entering at the MSB;
  - carry←adder co;
  - cnt increments.
- RUN, on the edge processing bit WIDTH-1 (cnt==WIDTH-1):
  - sum←{adder sum, s_sh[WIDTH-1:1]} and cout←adder co, both registered;
  - go to DONE.
- DONE: done=1 for this cycle only; go to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued, and the operands are not re-captured.
- Operand changes after the accepting edge have no effect on the addition in flight.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- cnt width is $clog2(WIDTH), minimum 1 bit.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; internal shift registers, carry and cnt are also 0.
- Latency: start accepted at edge E0. Bits are processed at edges E1..EWIDTH. done is high in the cycle following edge EWIDTH, i.e. WIDTH cycles after the accepting edge (4 for the default).
- busy is high from after E0 through EWIDTH, for exactly WIDTH cycles. busy is low while done is high.
- Back-to-back throughput: start may next be accepted at the edge ending the DONE cycle+1 (IDLE). Minimum issue interval is WIDTH+2 cycles.
- sum/cout change only at the completing edge. During RUN they show the previous result.
- Reset mid-operation: immediate abort, all outputs go to their reset values, and no done pulse is produced.
- start held high continuously gives a new addition every WIDTH+2 cycles using the currently applied operands.
- WIDTH=1: RUN lasts one cycle; done is high one cycle after the accepting edge.

## Structure
- Package fa4bit_pkg:
  - state typedef enum {IDLE, RUN, DONE};
  - default width constant FA_WIDTH=4.
- Sub-module full_adder: combinational one-bit adder with sum = a^b^cin and co = (a&b)|(a&cin)|(b&cin).
  - Instantiated once.
  - Reusable by the existing one-bit adder bench.
- Everything else is in the top level: FSM, shift registers, counter and result registers.

## Test plan
- Reset, then a=5, b=3, cin=0, start for 1 cycle → busy high for 4 cycles; done pulses on cycle 4 after acceptance; sum=8, cout=0.
- a=15, b=1, cin=0 → sum=0, cout=1. Then a=15, b=15, cin=1 → sum=15, cout=1.
- Pulse start again on cycle 2 of RUN with a=1, b=1 → ignored; the first result (5+3=8) is completed unchanged, and there is only one done pulse.
- Assert rst on cycle 2 of RUN → busy, done, sum and cout are all 0 immediately; there is no done pulse afterwards, and a following start works normally.
- Exhaustive sweep over all 512 {a,b,cin} combinations with start held high → every done pulse matches a+b+cin, and pulses are spaced exactly 6 cycles apart.
- WIDTH=1 instance: a=1, b=1, cin=1 → sum=1, cout=1, done 1 cycle after acceptance.
